// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter family: FSM encoding
// and a width helper that never returns zero.
package fifo_arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  function automatic int clog2_min1(input int value);
    return (value > 2) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_REQ. Reusable by any arbiter.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_id,
  output logic               any
);

  logic             found_s;
  logic [IDX_W-1:0] idx_s;

  // scan from ptr upward, keeping only the first hit
  always_comb begin
    pick    = '0;
    pick_id = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found_s && req[idx_s]) begin
        found_s     = 1'b1;
        pick[idx_s] = 1'b1;
        pick_id     = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers,
// granting bursts of up to MAX_BURST beats with one idle cycle between grants.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_valid,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            grant,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IDX_W = clog2_min1(NUM_REQ);
  localparam int CNT_W = clog2_min1(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  logic                  state_r;
  logic [IDX_W-1:0]      rr_ptr_r;
  logic [CNT_W-1:0]      beat_cnt_r;
  logic [NUM_REQ-1:0]    grant_r;
  logic [IDX_W-1:0]      grant_id_r;

  logic [NUM_REQ-1:0]    pick_s;
  logic [IDX_W-1:0]      pick_id_s;
  logic                  any_s;
  logic                  in_burst_s;
  logic                  g_valid_s;
  logic                  g_last_s;
  logic                  xfer_s;
  logic                  release_s;
  logic [NUM_REQ-1:0]    ready_s;
  logic [DATA_WIDTH-1:0] wr_data_s;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (req_valid),
    .ptr     (rr_ptr_r),
    .pick    (pick_s),
    .pick_id (pick_id_s),
    .any     (any_s)
  );

  assign in_burst_s = (state_r == ST_BURST);
  assign g_valid_s  = req_valid[grant_id_r];
  assign g_last_s   = req_last[grant_id_r];
  assign xfer_s     = in_burst_s && g_valid_s && !fifo_full;
  assign release_s  = in_burst_s &&
                      ((xfer_s && (g_last_s || (beat_cnt_r == LAST_BEAT))) || !g_valid_s);

  // ready decode: only the granted requester sees ready, and only when FIFO has room
  always_comb begin
    ready_s = '0;
    if (in_burst_s) begin
      ready_s[grant_id_r] = !fifo_full;
    end else begin
      ready_s = '0;
    end
  end

  // data mux driven from the registered grant so req_data never reaches control
  always_comb begin
    wr_data_s = '0;
    if (in_burst_s) begin
      wr_data_s = req_data[int'(grant_id_r) * DATA_WIDTH +: DATA_WIDTH];
    end else begin
      wr_data_s = '0;
    end
  end

  // arbitration FSM; grant_id deliberately keeps its value through IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      rr_ptr_r   <= '0;
      beat_cnt_r <= '0;
      grant_r    <= '0;
      grant_id_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            grant_r    <= pick_s;
            grant_id_r <= pick_id_s;
            beat_cnt_r <= '0;
            state_r    <= ST_BURST;
          end else begin
            grant_r <= '0;
          end
        end
        ST_BURST: begin
          if (release_s) begin
            rr_ptr_r   <= (grant_id_r == LAST_IDX) ? '0 : grant_id_r + IDX_W'(1);
            grant_r    <= '0;
            beat_cnt_r <= '0;
            state_r    <= ST_IDLE;
          end else if (xfer_s) begin
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
          end else begin
            beat_cnt_r <= beat_cnt_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= '0;
        end
      endcase
    end
  end

  assign req_ready     = ready_s;
  assign fifo_wr_valid = xfer_s;
  assign fifo_wr_data  = wr_data_s;
  assign grant         = grant_r;
  assign grant_id      = grant_id_r;
  assign busy          = in_burst_s;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producer queues drive requests, expected
// bursts and FIFO writes are queued up front and retired as the DUT produces them.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int MAXB    = 4;

  logic                   clk;
  logic                   rst;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*DW-1:0]  req_data;
  logic [NUM_REQ-1:0]     req_last;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   fifo_wr_valid;
  logic [DW-1:0]          fifo_wr_data;
  logic                   fifo_full;
  logic [NUM_REQ-1:0]     grant;
  logic [1:0]             grant_id;
  logic                   busy;

  fifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MAXB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .fifo_wr_valid (fifo_wr_valid),
    .fifo_wr_data  (fifo_wr_data),
    .fifo_full     (fifo_full),
    .grant         (grant),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int gid; int beats; bit gap; } burst_t;

  burst_t        exp_burst_q[$];
  logic [DW-1:0] exp_data_q[$];
  logic [DW:0]   pq[NUM_REQ][$];

  int err_cnt = 0;
  int chk_cnt = 0;
  bit in_burst = 1'b0;
  int cur_gid = 0;
  int cur_beats = 0;
  int cur_exp_beats = 0;
  int idle_run = 0;
  int full_left = 0;
  int rst_left = 3;
  bit rst_d = 1'b1;
  bit bp_arm = 1'b0;
  bit rst_arm = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pq[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_data[i*DW +: DW] = pq[i][0][DW-1:0];
        req_last[i]          = pq[i][0][DW];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  task automatic load(input int r, input int n, input int base, input bit last_end);
    for (int k = 0; k < n; k++)
      pq[r].push_back({(last_end && (k == n - 1)), DW'(base + k)});
  endtask

  task automatic push_burst(input int g, input int b, input bit gp);
    burst_t e;
    e.gid = g; e.beats = b; e.gap = gp;
    exp_burst_q.push_back(e);
  endtask

  task automatic push_data(input int base, input int n);
    for (int k = 0; k < n; k++) exp_data_q.push_back(DW'(base + k));
  endtask

  function automatic bit prod_empty();
    bit e = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) if (pq[i].size() > 0) e = 1'b0;
    return e;
  endfunction

  // one clock: sample at negedge, then update stimulus just after posedge
  task automatic tick();
    logic [NUM_REQ-1:0] xfer;
    logic [NUM_REQ-1:0] exp_vec;
    burst_t b;
    @(negedge clk);
    xfer = req_valid & req_ready & {NUM_REQ{~rst}};
    if (rst_d) begin
      check_val("rst_grant", 32'(grant), 32'd0);
      check_val("rst_grant_id", 32'(grant_id), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_wr_valid", 32'(fifo_wr_valid), 32'd0);
      check_val("rst_wr_data", 32'(fifo_wr_data), 32'd0);
    end
    if (busy && !in_burst) begin
      check_val("burst_expected", 32'(exp_burst_q.size() > 0), 32'd1);
      cur_gid = 0; cur_exp_beats = 0;
      if (exp_burst_q.size() > 0) begin
        b = exp_burst_q.pop_front();
        cur_gid = b.gid; cur_exp_beats = b.beats;
        if (b.gap) check_val("idle_bubble", 32'(idle_run), 32'd1);
      end
      in_burst = 1'b1; cur_beats = 0;
    end else if (!busy && in_burst) begin
      check_val("burst_beats", 32'(cur_beats), 32'(cur_exp_beats));
      in_burst = 1'b0;
    end
    if (in_burst) begin
      exp_vec = '0; exp_vec[cur_gid] = 1'b1;
      check_val("grant", 32'(grant), 32'(exp_vec));
      check_val("grant_id", 32'(grant_id), 32'(cur_gid));
      exp_vec = '0; exp_vec[cur_gid] = !fifo_full;
      check_val("req_ready", 32'(req_ready), 32'(exp_vec));
      check_val("wr_valid", 32'(fifo_wr_valid), 32'(req_valid[cur_gid] && !fifo_full));
    end else begin
      check_val("idle_grant", 32'(grant), 32'd0);
      check_val("idle_ready", 32'(req_ready), 32'd0);
      check_val("idle_wr_valid", 32'(fifo_wr_valid), 32'd0);
    end
    if (fifo_wr_valid && !rst) begin
      check_val("wr_expected", 32'(exp_data_q.size() > 0), 32'd1);
      if (exp_data_q.size() > 0) check_val("wr_data", 32'(fifo_wr_data), 32'(exp_data_q.pop_front()));
      cur_beats++;
    end
    idle_run = busy ? 0 : idle_run + 1;
    if (full_left > 0) full_left--;
    if (bp_arm && in_burst && cur_beats == 1) begin full_left = 5; bp_arm = 1'b0; end
    if (rst_arm && in_burst && cur_beats == 2) begin rst_left = 2; rst_arm = 1'b0; end
    @(posedge clk);
    #1;
    rst_d = rst;
    if (rst_left > 0) rst_left--;
    rst = (rst_left > 0);
    fifo_full = (full_left > 0);
    for (int i = 0; i < NUM_REQ; i++) if (xfer[i]) void'(pq[i].pop_front());
    apply_inputs();
  endtask

  task automatic wait_done();
    int n = 0;
    while (n < 400 && !(exp_burst_q.size() == 0 && exp_data_q.size() == 0 && !in_burst && prod_empty())) begin
      tick();
      n++;
    end
    check_val("drain_bursts", 32'(exp_burst_q.size()), 32'd0);
    check_val("drain_data", 32'(exp_data_q.size()), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; fifo_full = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;

    // reset with everyone requesting, then single-beat packets drain in order
    for (int i = 0; i < NUM_REQ; i++) begin
      load(i, 1, 8'hF0 + i, 1'b1);
      push_burst(i, 1, i != 0);
    end
    push_data(8'hF0, 4);
    apply_inputs();
    repeat (3) tick();
    wait_done();

    // fairness: all continuously valid, no last, MAX_BURST bursts
    load(0, 8, 8'h00, 1'b0);
    load(1, 4, 8'h10, 1'b0);
    load(2, 4, 8'h20, 1'b0);
    load(3, 4, 8'h30, 1'b0);
    push_burst(0, 4, 1'b0); push_burst(1, 4, 1'b1); push_burst(2, 4, 1'b1);
    push_burst(3, 4, 1'b1); push_burst(0, 4, 1'b1);
    push_data(8'h00, 4); push_data(8'h10, 4); push_data(8'h20, 4);
    push_data(8'h30, 4); push_data(8'h04, 4);
    apply_inputs();
    wait_done();

    // early release on last, requester 3 pending
    load(2, 2, 8'hA1, 1'b1);
    load(3, 2, 8'hB1, 1'b1);
    push_burst(2, 2, 1'b0); push_burst(3, 2, 1'b1);
    push_data(8'hA1, 2); push_data(8'hB1, 2);
    apply_inputs();
    wait_done();

    // backpressure: FIFO full for 5 cycles after the first beat
    bp_arm = 1'b1;
    load(1, 4, 8'hC0, 1'b0);
    push_burst(1, 4, 1'b0);
    push_data(8'hC0, 4);
    apply_inputs();
    wait_done();
    check_val("bp_applied", 32'(bp_arm), 32'd0);

    // requester drop after one beat, then wrap to 0 and continue to 1
    load(2, 1, 8'hD8, 1'b0);
    load(0, 2, 8'h50, 1'b1);
    load(1, 2, 8'h60, 1'b1);
    push_burst(2, 1, 1'b0); push_burst(0, 2, 1'b1); push_burst(1, 2, 1'b1);
    push_data(8'hD8, 1); push_data(8'h50, 2); push_data(8'h60, 2);
    apply_inputs();
    wait_done();

    // reset mid-burst at beat 2, arbitration restarts from requester 0
    rst_arm = 1'b1;
    load(2, 4, 8'hD0, 1'b0);
    load(0, 2, 8'hE0, 1'b1);
    push_burst(2, 2, 1'b0); push_burst(0, 2, 1'b1); push_burst(2, 2, 1'b1);
    push_data(8'hD0, 2); push_data(8'hE0, 2); push_data(8'hD2, 2);
    apply_inputs();
    wait_done();
    check_val("rst_applied", 32'(rst_arm), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
